// File: rtl/mem_access.sv
// mem_access: memory-access stage of the five-stage RV32I pipeline.
// Loads and stores go byte-serially, little-endian, through a byte-wide synchronous RAM.
// The pipeline is held with stall_req_o until the access completes.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
// Op-code constants mirror the encoding in defines.v (ALU_OP_BUS = 8 bits).
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  ram_rdata_i,
  output logic [31:0] ram_addr_o,
  output logic [7:0]  ram_wdata_o,
  output logic        ram_we_o,
  output logic        stall_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  localparam logic [7:0] ExeLbOp  = 8'h20;
  localparam logic [7:0] ExeLhOp  = 8'h21;
  localparam logic [7:0] ExeLwOp  = 8'h23;
  localparam logic [7:0] ExeLbuOp = 8'h24;
  localparam logic [7:0] ExeLhuOp = 8'h25;
  localparam logic [7:0] ExeSbOp  = 8'h28;
  localparam logic [7:0] ExeShOp  = 8'h29;
  localparam logic [7:0] ExeSwOp  = 8'h2B;

  localparam logic [4:0]  NopRegAddr = 5'd0;
  localparam logic [31:0] Zero32     = 32'd0;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;

  logic        is_load, is_store, is_mem, sext;
  logic [2:0]  size;
  logic        misaligned;
  logic [1:0]  cap_idx;
  logic [31:0] load_ext;

  // Decode the op into access size, direction and sign-extension.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = 3'd0;
    case (aluop_i)
      ExeLbOp:  begin is_load  = 1'b1; sext = 1'b1; size = 3'd1; end
      ExeLhOp:  begin is_load  = 1'b1; sext = 1'b1; size = 3'd2; end
      ExeLwOp:  begin is_load  = 1'b1;              size = 3'd4; end
      ExeLbuOp: begin is_load  = 1'b1;              size = 3'd1; end
      ExeLhuOp: begin is_load  = 1'b1;              size = 3'd2; end
      ExeSbOp:  begin is_store = 1'b1;              size = 3'd1; end
      ExeShOp:  begin is_store = 1'b1;              size = 3'd2; end
      ExeSwOp:  begin is_store = 1'b1;              size = 3'd4; end
      default:  ;
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem && (((size == 3'd2) && mem_addr_i[0]) ||
                                 ((size == 3'd4) && (mem_addr_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // cnt counts 1..N in ACCESS; the byte arriving now belongs to address cnt-1.
  assign cap_idx = cnt_q[1:0] - 2'd1;

  // Zero/sign-extend the assembled load value.
  always_comb begin
    load_ext = buf_q;
    if (size == 3'd1) begin
      load_ext = {{24{sext & buf_q[7]}}, buf_q[7:0]};
    end else if (size == 3'd2) begin
      load_ext = {{16{sext & buf_q[15]}}, buf_q[15:0]};
    end
  end

  // State, byte counter and load assembly register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic and all outputs; reset forces the outputs to their idle values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    ram_addr_o  = 32'd0;
    ram_wdata_o = 8'd0;
    ram_we_o    = 1'b0;
    stall_req_o = 1'b0;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    misalign_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          stall_req_o = 1'b1;
          wreg_o      = 1'b0;
          if (misaligned) begin
            state_d = StDone;
            cnt_d   = 3'd0;
          end else begin
            ram_addr_o  = mem_addr_i;
            ram_we_o    = is_store;
            ram_wdata_o = is_store ? mem_wdata_i[7:0] : 8'd0;
            if (is_store && (size == 3'd1)) begin
              state_d = StDone;
              cnt_d   = 3'd0;
            end else begin
              state_d = StAccess;
              cnt_d   = 3'd1;
            end
          end
        end
      end
      StAccess: begin
        stall_req_o = 1'b1;
        wreg_o      = 1'b0;
        ram_addr_o  = mem_addr_i + {29'd0, cnt_q};
        if (is_load) begin
          buf_d[{cap_idx, 3'b000} +: 8] = ram_rdata_i;
          if (cnt_q == size) begin
            state_d = StDone;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (is_store) begin
          ram_we_o    = 1'b1;
          ram_wdata_o = 8'(mem_wdata_i >> {cnt_q, 3'b000});
          if (cnt_q == size - 3'd1) begin
            state_d = StDone;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          // Op vanished mid-access; inputs are meant to be held, so just recover.
          state_d = StIdle;
          cnt_d   = 3'd0;
        end
      end
      StDone: begin
        state_d    = StIdle;
        cnt_d      = 3'd0;
        misalign_o = misaligned;
        if (is_store || misaligned) begin
          wreg_o = 1'b0;
        end else if (is_load) begin
          wdata_o = load_ext;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase

    if (rst) begin
      ram_addr_o  = 32'd0;
      ram_wdata_o = 8'd0;
      ram_we_o    = 1'b0;
      stall_req_o = 1'b0;
      wd_o        = NopRegAddr;
      wreg_o      = 1'b0;
      wdata_o     = Zero32;
      misalign_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access with a byte-RAM model
// and a shadow-memory reference model. Honors MEM_ALIGN_CHECK_EN when defined.
module tb_mem_access;

  localparam logic [7:0] LB  = 8'h20;
  localparam logic [7:0] LH  = 8'h21;
  localparam logic [7:0] LW  = 8'h23;
  localparam logic [7:0] LBU = 8'h24;
  localparam logic [7:0] LHU = 8'h25;
  localparam logic [7:0] SB  = 8'h28;
  localparam logic [7:0] SH  = 8'h29;
  localparam logic [7:0] SW  = 8'h2B;
  localparam logic [7:0] ADD = 8'h0A;
  localparam int unsigned MemBytes = 1024;

  logic        clk, rst;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, mem_wdata, wdata_in;
  logic [4:0]  wd_in;
  logic        wreg_in;
  logic [7:0]  ram_rdata;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we, stall_req;
  logic [4:0]  wd_out;
  logic        wreg_out;
  logic [31:0] wdata_out;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram     [MemBytes];
  logic [7:0] ref_mem [MemBytes];

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .wd_i        (wd_in),
    .wreg_i      (wreg_in),
    .wdata_i     (wdata_in),
    .ram_rdata_i (ram_rdata),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .stall_req_o (stall_req),
    .wd_o        (wd_out),
    .wreg_o      (wreg_out),
    .wdata_o     (wdata_out),
    .misalign_o  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM, aliased modulo MemBytes.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr % MemBytes] <= ram_wdata;
    ram_rdata <= ram[ram_addr % MemBytes];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input logic [7:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction

  // Drive one instruction just after a rising edge, follow it to completion, and leave
  // the bench just after the edge on which the pipeline advances.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic wr, input logic [31:0] alu);
    int n, total, cyc;
    bit ld, st, sx, mis;
    logic [31:0] raw, exp_val;
    n  = op_size(op);
    ld = (op == LB || op == LH || op == LW || op == LBU || op == LHU);
    st = (op == SB || op == SH || op == SW);
    sx = (op == LB || op == LH);
`ifdef MEM_ALIGN_CHECK_EN
    mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    total = (n == 0) ? 1 : (mis ? 2 : (ld ? n + 2 : n + 1));
    aluop = op; mem_addr = addr; mem_wdata = sdata; wd_in = rd; wreg_in = wr; wdata_in = alu;

    raw = 32'd0;
    for (int k = 0; k < n; k++) raw = raw + (32'(ref_mem[(addr + 32'(k)) % MemBytes]) << (8 * k));
    exp_val = raw;
    if (sx && raw[8 * n - 1]) exp_val = raw - (32'd1 << (8 * n));

    cyc = 0;
    @(negedge clk);
    while (stall_req === 1'b1) begin
      chk("stall_wreg", {31'd0, wreg_out}, 32'd0);
      if (!mis && cyc < n) begin
        chk("ram_addr", ram_addr, addr + 32'(cyc));
        chk("ram_we", {31'd0, ram_we}, {31'd0, st});
        if (st) chk("ram_wdata", {24'd0, ram_wdata}, (sdata >> (8 * cyc)) & 32'hFF);
      end else begin
        chk("ram_we_idle", {31'd0, ram_we}, 32'd0);
      end
      cyc++;
      if (cyc > 20) begin
        failures++;
        $error("FAIL timeout observed=stall_stuck expected=release op=%h", op);
        break;
      end
      @(negedge clk);
    end
    chk("stall_cycles", 32'(cyc), 32'(total - 1));
    chk("done_we", {31'd0, ram_we}, 32'd0);
    chk("wd_o", {27'd0, wd_out}, {27'd0, rd});
    chk("misalign", {31'd0, misalign}, {31'd0, mis});
    if (n == 0) begin
      chk("wreg_pass", {31'd0, wreg_out}, {31'd0, wr});
      chk("wdata_pass", wdata_out, alu);
    end else if (ld && !mis) begin
      chk("load_wreg", {31'd0, wreg_out}, {31'd0, wr});
      chk("load_data", wdata_out, exp_val);
    end else begin
      chk("nowrite_wreg", {31'd0, wreg_out}, 32'd0);
    end
    if (st && !mis)
      for (int k = 0; k < n; k++) ref_mem[(addr + 32'(k)) % MemBytes] = 8'(sdata >> (8 * k));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, ram_addr, 32'd0);
    chk({tag, "_we"}, {31'd0, ram_we}, 32'd0);
    chk({tag, "_wdata8"}, {24'd0, ram_wdata}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_wd"}, {27'd0, wd_out}, 32'd0);
    chk({tag, "_wreg"}, {31'd0, wreg_out}, 32'd0);
    chk({tag, "_wdata"}, wdata_out, 32'd0);
    chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
  endtask

  logic [7:0] ops [9];
  logic [31:0] a, d;

  initial begin
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD};
    rst = 1'b1;
    aluop = SW; mem_addr = 32'h40; mem_wdata = 32'hA5A5A5A5;
    wd_in = 5'd7; wreg_in = 1'b1; wdata_in = 32'h1234;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill every word through the DUT so RAM and reference agree.
    for (int i = 0; i < MemBytes / 4; i++) run_op(SW, 32'(i * 4), $urandom, 5'd0, 1'b0, 32'd0);

    // Directed cases.
    run_op(SW, 32'h100, 32'h12345678, 5'd0, 1'b0, 32'd0);
    run_op(LW, 32'h100, 32'd0, 5'd5, 1'b1, 32'h0);
    run_op(SB, 32'h200, 32'h00000080, 5'd0, 1'b0, 32'd0);
    run_op(LB, 32'h200, 32'd0, 5'd6, 1'b1, 32'd0);
    run_op(LBU, 32'h200, 32'd0, 5'd6, 1'b1, 32'd0);
    run_op(SH, 32'h210, 32'h00008001, 5'd0, 1'b0, 32'd0);
    run_op(LH, 32'h210, 32'd0, 5'd8, 1'b1, 32'd0);
    run_op(LHU, 32'h210, 32'd0, 5'd8, 1'b1, 32'd0);
    run_op(SW, 32'h300, 32'hDEADBEEF, 5'd9, 1'b1, 32'd0);
    run_op(LW, 32'h300, 32'd0, 5'd9, 1'b1, 32'd0);
    run_op(ADD, 32'h0, 32'd0, 5'd3, 1'b1, 32'd5);
    run_op(LW, 32'h102, 32'd0, 5'd4, 1'b1, 32'd0);
    run_op(LW, 32'hFFFF_FFFE, 32'd0, 5'd4, 1'b1, 32'd0);

    // Reset in the middle of a SW, during byte 2.
    aluop = SW; mem_addr = 32'h380; mem_wdata = 32'hCAFEF00D; wd_in = 5'd1; wreg_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_sw_we", {31'd0, ram_we}, 32'd1);
    chk("mid_sw_addr", ram_addr, 32'h382);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    ref_mem[10'h380] = 8'h0D;
    ref_mem[10'h381] = 8'hF0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_op(SB, 32'h3F0, 32'h0000005A, 5'd0, 1'b0, 32'd0);
    run_op(LW, 32'h380, 32'd0, 5'd2, 1'b1, 32'd0);
    run_op(LBU, 32'h3F0, 32'd0, 5'd2, 1'b1, 32'd0);

    // Randomized mix, back to back.
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(ops[$urandom_range(0, 8)], a, d, 5'($urandom), 1'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
